fifo_axis_drain: RTL

- Downstream consumer of a synchronous FIFO.
- Drives the FIFO read strobe and captures read data, which the FIFO presents one cycle after the read.
- Re-emits that data as an AXI-Stream master with full backpressure support.
- Frames the stream into packets of a programmable beat count, asserting tlast on the last beat of each packet; sits between the FIFO and the AXI-Stream fabric.

---
 rtl/fifo_axis_drain_if.sv | 34 +++
 rtl/fifo_axis_drain.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fifo_axis_drain_if.sv
// Bus bundle for fifo_axis_drain: the FIFO read side and the AXI-Stream master side.
// The master modport is the drain block itself; the slave modport is whatever
// sits on the other side (the FIFO plus the stream sink).
interface fifo_axis_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_mty;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;

    modport master (
        output fifo_rd,
        input  fifo_q,
        input  fifo_mty,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata,
        output m_axis_tlast
    );

    modport slave (
        input  fifo_rd,
        output fifo_q,
        output fifo_mty,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tlast
    );
endinterface

// File: rtl/fifo_axis_drain.sv
// fifo_axis_drain: pulls words out of a synchronous FIFO (data one cycle after
// the read strobe), holds them in a 2-entry buffer and re-emits them as an
// AXI-Stream master, cutting the stream into packets of pkt_len beats.
//
// Stream handshake: a beat transfers on a rising edge where tvalid and tready
// are both high. tvalid is raised only when a beat is held in the buffer and
// never drops until that beat transfers; while tvalid=1 and tready=0 the
// tdata and tlast outputs do not change.
module fifo_axis_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [LEN_W-1:0] pkt_len,
    fifo_axis_drain_if.master bus,
    output logic [CNT_W-1:0] pkt_done_cnt
);

    // Output buffer: two slots, head pointer and occupancy.
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  hd_q, hd_d;
    logic [1:0]            occ_q, occ_d;
    // Registered copy of the read strobe: a FIFO word lands on fifo_q this cycle.
    logic                  infl_q, infl_d;
    // Packet framing state.
    logic [LEN_W-1:0]      bcnt_q, bcnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  pop;
    logic                  last_beat;
    logic                  rd;
    logic                  tail;
    logic [2:0]            credit_after;
    logic [LEN_W-1:0]      pkt_len_eff;

    // Handshake, framing and read-credit terms shared by the next-state logic.
    // The read strobe counts a same-cycle pop as freed space so that a full
    // pipeline keeps reading every cycle; this gives tready a combinational
    // path to fifo_rd. Reset gates the strobe so the FIFO is never read while
    // rst_n is low.
    always_comb begin
        pop          = (occ_q != 2'd0) && bus.m_axis_tready;
        last_beat    = (occ_q != 2'd0) && (bcnt_q == (len_q - LEN_W'(1)));
        credit_after = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
        rd           = rst_n && enable && !bus.fifo_mty && (credit_after <= 3'd1);
        tail         = hd_q ^ occ_q[0];
        pkt_len_eff  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    end

    // Next-state: capture the in-flight word at the tail, pop the head on a
    // handshake, and advance the packet framing.
    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        hd_d     = hd_q;
        occ_d    = occ_q + {1'b0, infl_q} - {1'b0, pop};
        infl_d   = rd;
        bcnt_d   = bcnt_q;
        len_d    = len_q;
        cnt_d    = cnt_q;

        if (infl_q) begin
            buf_d[tail] = bus.fifo_q;
        end

        if (pop) begin
            hd_d = ~hd_q;
            if (last_beat) begin
                // The next head beat starts a new packet; take its length now
                // so tlast is settled before that beat is presented.
                bcnt_d = '0;
                cnt_d  = cnt_q + CNT_W'(1);
                len_d  = pkt_len_eff;
            end else begin
                bcnt_d = bcnt_q + LEN_W'(1);
            end
        end else if ((bcnt_q == '0) && (occ_q == 2'd0)) begin
            // Between packets with nothing presented: track pkt_len so the
            // first beat of the next packet sees the current setting.
            len_d = pkt_len_eff;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            hd_q     <= 1'b0;
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
            bcnt_q   <= '0;
            len_q    <= LEN_W'(1);
            cnt_q    <= '0;
        end else begin
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            hd_q     <= hd_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
            bcnt_q   <= bcnt_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs come straight from buffer storage and framing registers.
    always_comb begin
        bus.fifo_rd       = rd;
        bus.m_axis_tvalid = (occ_q != 2'd0);
        bus.m_axis_tdata  = buf_q[hd_q];
        bus.m_axis_tlast  = last_beat;
        pkt_done_cnt      = cnt_q;
    end

    // Buffered plus in-flight words never exceed the two buffer slots.
    occ_infl_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, occ_q} + {2'b0, infl_q}) <= 3'd2);

endmodule
